// File: rtl/r22_pkg.sv
// Shared constants for the radix-2^2 64-point SDF FFT.
// This package is imported by the twiddle scheduler and its address generator.
package r22_pkg;
  localparam int LOG_N  = 6;
  localparam int N      = 64;
  localparam int TW_W   = 6;
  localparam int LOG_M1 = 6;
  localparam int LOG_M2 = 4;

  typedef logic [TW_W-1:0] taddr_t;
endpackage

// File: rtl/twiddle_addr_gen.sv
// Maps a stage sample count to its twiddle table address and multiply flag.
// One instance is used for each twiddle stage; LOG_M selects the stage.
module twiddle_addr_gen
  import r22_pkg::*;
#(
  parameter int LOG_M = LOG_M1
) (
  input  logic [LOG_M-1:0] i_cnt,
  output taddr_t           o_taddr,
  output logic             o_mul
);

  taddr_t w_n;
  taddr_t w_k;
  taddr_t w_prod;

  // k is the bit-reversed quarter index; the product is rescaled to the N-point table.
  always_comb begin
    w_n              = '0;
    w_n[LOG_M-3:0]   = i_cnt[LOG_M-3:0];
    w_k              = '0;
    w_k[1:0]         = {i_cnt[LOG_M-2], i_cnt[LOG_M-1]};
    w_prod           = w_n * w_k;
    o_taddr          = w_prod << (LOG_N - LOG_M);
    o_mul            = |o_taddr;
  end

endmodule

// File: rtl/twiddle_sched.sv
// Twiddle-address scheduler for the two twiddle stages of the 64-point SDF FFT.
// It keeps one sample counter per stage and issues an address, a mul flag and frame pulses.
module twiddle_sched
  import r22_pkg::*;
#(
  parameter int TW_FF = 1
) (
  input  logic   clock,
  input  logic   reset_n,
  input  logic   clear,
  input  logic   s1_en,
  input  logic   s2_en,
  output taddr_t s1_taddr,
  output logic   s1_mul,
  output logic   s1_tvalid,
  output taddr_t s2_taddr,
  output logic   s2_mul,
  output logic   s2_tvalid,
  output logic   s1_fstart,
  output logic   s2_fdone
);

  logic [LOG_N-1:0] r_c1;
  logic [LOG_N-1:0] r_c2;

  taddr_t w_s1_raw;
  taddr_t w_s2_raw;
  logic   w_s1_mul_raw;
  logic   w_s2_mul_raw;

  // Handshake: sX_en is a valid-only strobe with no ready; sX_tvalid marks the matching
  // output beat, and outputs are held at zero on beats without a valid sample.
  logic   w_s1_v;
  logic   w_s2_v;
  taddr_t w_s1_taddr;
  taddr_t w_s2_taddr;
  logic   w_s1_mul;
  logic   w_s2_mul;
  logic   w_s1_fstart;
  logic   w_s2_fdone;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_c1 <= '0;
      r_c2 <= '0;
    end else if (clear) begin
      r_c1 <= '0;
      r_c2 <= '0;
    end else begin
      if (s1_en) r_c1 <= r_c1 + 6'd1;
      if (s2_en) r_c2 <= r_c2 + 6'd1;
    end
  end

  twiddle_addr_gen #(.LOG_M(LOG_M1)) u_s1_gen (
    .i_cnt   (r_c1[LOG_M1-1:0]),
    .o_taddr (w_s1_raw),
    .o_mul   (w_s1_mul_raw)
  );

  twiddle_addr_gen #(.LOG_M(LOG_M2)) u_s2_gen (
    .i_cnt   (r_c2[LOG_M2-1:0]),
    .o_taddr (w_s2_raw),
    .o_mul   (w_s2_mul_raw)
  );

  // A clear discards the sample offered in the same cycle, so it never reaches the outputs.
  always_comb begin
    w_s1_v      = s1_en & ~clear;
    w_s2_v      = s2_en & ~clear;
    w_s1_taddr  = w_s1_v ? w_s1_raw : '0;
    w_s2_taddr  = w_s2_v ? w_s2_raw : '0;
    w_s1_mul    = w_s1_v & w_s1_mul_raw;
    w_s2_mul    = w_s2_v & w_s2_mul_raw;
    w_s1_fstart = w_s1_v & (r_c1 == 6'd0);
    w_s2_fdone  = w_s2_v & (r_c2 == 6'd63);
  end

  generate
    if (TW_FF != 0) begin : g_reg
      taddr_t r_s1_taddr;
      taddr_t r_s2_taddr;
      logic   r_s1_mul;
      logic   r_s2_mul;
      logic   r_s1_tvalid;
      logic   r_s2_tvalid;
      logic   r_s1_fstart;
      logic   r_s2_fdone;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_s1_taddr  <= '0;
          r_s2_taddr  <= '0;
          r_s1_mul    <= 1'b0;
          r_s2_mul    <= 1'b0;
          r_s1_tvalid <= 1'b0;
          r_s2_tvalid <= 1'b0;
          r_s1_fstart <= 1'b0;
          r_s2_fdone  <= 1'b0;
        end else begin
          r_s1_taddr  <= w_s1_taddr;
          r_s2_taddr  <= w_s2_taddr;
          r_s1_mul    <= w_s1_mul;
          r_s2_mul    <= w_s2_mul;
          r_s1_tvalid <= w_s1_v;
          r_s2_tvalid <= w_s2_v;
          r_s1_fstart <= w_s1_fstart;
          r_s2_fdone  <= w_s2_fdone;
        end
      end

      assign s1_taddr  = r_s1_taddr;
      assign s2_taddr  = r_s2_taddr;
      assign s1_mul    = r_s1_mul;
      assign s2_mul    = r_s2_mul;
      assign s1_tvalid = r_s1_tvalid;
      assign s2_tvalid = r_s2_tvalid;
      assign s1_fstart = r_s1_fstart;
      assign s2_fdone  = r_s2_fdone;
    end else begin : g_comb
      assign s1_taddr  = w_s1_taddr;
      assign s2_taddr  = w_s2_taddr;
      assign s1_mul    = w_s1_mul;
      assign s2_mul    = w_s2_mul;
      assign s1_tvalid = w_s1_v;
      assign s2_tvalid = w_s2_v;
      assign s1_fstart = w_s1_fstart;
      assign s2_fdone  = w_s2_fdone;
    end
  endgenerate

endmodule
